// File: rtl/datamem_pkg.sv
// Shared state encoding and default sizing for the datamem_pipe data memory.
package datamem_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DEPTH_DEF  = 32;

    typedef logic [0:0] state_t;

    localparam state_t CLEAR = 1'b0;
    localparam state_t READY = 1'b1;

endpackage

// File: rtl/datamem_array.sv
// Single-port synchronous RAM: per-byte write enable, registered read data that
// holds its value between reads and clears on reset.
module datamem_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned BE_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] bit_mask;

    // Expand byte enables to a per-bit write mask
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            bit_mask[i] = be[i / 8];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= (mem[addr] & ~bit_mask) | (wdata & bit_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/datamem_pipe.sv
// Data memory with power-up clear sweep and 1-cycle read latency.
// Optional byte-enable writes are built when DATAMEM_BYTE_EN_EN is defined.
module datamem_pipe
    import datamem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_DM,
    input  logic                we_DM,
    input  logic [ADDR_W-1:0]   addDM,
    input  logic [DATA_W-1:0]   dataDM,
`ifdef DATAMEM_BYTE_EN_EN
    input  logic [DATA_W/8-1:0] be_DM,
`endif
    output logic                rdy_DM,
    output logic [DATA_W-1:0]   outDM,
    output logic                vld_DM,
    output logic                err_DM
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DATAMEM_BYTE_EN_EN
    localparam int unsigned BE_W  = DATA_W / 8;
`else
    localparam int unsigned BE_W  = (DATA_W + 7) / 8;
`endif

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  clr_ptr;
    logic [IDX_W-1:0]  clr_ptr_next;
    logic              accept_c;
    logic              in_range_c;
    logic              arr_we;
    logic              arr_re;
    logic [IDX_W-1:0]  arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [BE_W-1:0]   arr_be;
    logic [BE_W-1:0]   user_be;

`ifdef DATAMEM_BYTE_EN_EN
    assign user_be = be_DM;
`else
    assign user_be = '1;
`endif

    // Full-width compare so out-of-range addresses never alias into the array
    assign in_range_c = ({1'b0, addDM} < (ADDR_W+1)'(DEPTH));
    assign accept_c   = req_DM && rdy_DM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            rdy_DM  <= 1'b0;
            vld_DM  <= 1'b0;
            err_DM  <= 1'b0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
            rdy_DM  <= (state_next == READY);
            vld_DM  <= accept_c && !we_DM && in_range_c;
            err_DM  <= accept_c && !in_range_c;
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        arr_we       = 1'b0;
        arr_re       = 1'b0;
        arr_addr     = IDX_W'(addDM);
        arr_wdata    = dataDM;
        arr_be       = user_be;
        case (state)
            CLEAR: begin
                arr_we       = !rst;
                arr_addr     = clr_ptr;
                arr_wdata    = '0;
                arr_be       = '1;
                clr_ptr_next = clr_ptr + IDX_W'(1);
                if (clr_ptr == IDX_W'(DEPTH - 1)) begin
                    state_next   = READY;
                    clr_ptr_next = '0;
                end
            end
            READY: begin
                arr_we = accept_c && we_DM && in_range_c && !rst;
                arr_re = accept_c && !we_DM && in_range_c && !rst;
            end
            default: state_next = CLEAR;
        endcase
    end

    datamem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .BE_W   (BE_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .be    (arr_be),
        .rdata (outDM)
    );

endmodule

// File: tb/tb_datamem_pipe.sv
// Directed self-checking bench for datamem_pipe with default parameters.
// Covers both builds: with and without DATAMEM_BYTE_EN_EN.
module tb_datamem_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_DM;
    logic        we_DM;
    logic [11:0] addDM;
    logic [15:0] dataDM;
    logic [1:0]  be_DM;
    logic        rdy_DM;
    logic [15:0] outDM;
    logic        vld_DM;
    logic        err_DM;

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    datamem_pipe dut (
        .clk    (clk),
        .rst    (rst),
        .req_DM (req_DM),
        .we_DM  (we_DM),
        .addDM  (addDM),
        .dataDM (dataDM),
`ifdef DATAMEM_BYTE_EN_EN
        .be_DM  (be_DM),
`endif
        .rdy_DM (rdy_DM),
        .outDM  (outDM),
        .vld_DM (vld_DM),
        .err_DM (err_DM)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [11:0] a,
                         input logic [15:0] d, input logic [1:0] be);
        req_DM = req;
        we_DM  = we;
        addDM  = a;
        dataDM = d;
        be_DM  = be;
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        cnt = 0;
        while (!rdy_DM && cnt < 100) begin
            cnt++;
            step();
        end
        req_DM = 1'b0;
        check(tag, 32'(cnt), 32'(exp_cycles));
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 12'd0, 16'd0, 2'b11);
        #2;

        // Reset and clear sweep
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_rdy", 32'(rdy_DM), 32'd0);
        check("rst_vld", 32'(vld_DM), 32'd0);
        check("rst_err", 32'(err_DM), 32'd0);
        check("rst_out", 32'(outDM), 32'd0);
        wait_ready("clear_len", 32);
        check("rdy_after_clear", 32'(rdy_DM), 32'd1);

        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 12'(i), 16'd0, 2'b11);
            step();
            check("clr_rd_vld", 32'(vld_DM), 32'd1);
            check("clr_rd_data", 32'(outDM), 32'd0);
        end
        drive(1'b0, 1'b0, 12'd0, 16'd0, 2'b11);
        step();
        check("idle_vld", 32'(vld_DM), 32'd0);

        // Write then read the same address on the next cycle
        drive(1'b1, 1'b1, 12'd5, 16'hBEEF, 2'b11);
        step();
        check("wr5_vld", 32'(vld_DM), 32'd0);
        check("wr5_err", 32'(err_DM), 32'd0);
        check("wr5_out_hold", 32'(outDM), 32'd0);
        drive(1'b1, 1'b0, 12'd5, 16'h0000, 2'b11);
        step();
        check("rd5_vld", 32'(vld_DM), 32'd1);
        check("rd5_data", 32'(outDM), 32'hBEEF);
        drive(1'b0, 1'b0, 12'd0, 16'd0, 2'b11);
        step();
        check("rd5_vld_pulse", 32'(vld_DM), 32'd0);
        check("rd5_out_hold", 32'(outDM), 32'hBEEF);

        // Out-of-range accesses must not alias onto address 8
        drive(1'b1, 1'b1, 12'd8, 16'h1111, 2'b11);
        step();
        drive(1'b1, 1'b1, 12'd40, 16'h1234, 2'b11);
        step();
        check("wr40_err", 32'(err_DM), 32'd1);
        check("wr40_vld", 32'(vld_DM), 32'd0);
        drive(1'b1, 1'b0, 12'd40, 16'd0, 2'b11);
        step();
        check("rd40_err", 32'(err_DM), 32'd1);
        check("rd40_vld", 32'(vld_DM), 32'd0);
        check("rd40_out_hold", 32'(outDM), 32'hBEEF);
        drive(1'b1, 1'b1, 12'h808, 16'h9999, 2'b11);
        step();
        check("wr808_err", 32'(err_DM), 32'd1);
        drive(1'b1, 1'b0, 12'd8, 16'd0, 2'b11);
        step();
        check("rd8_err", 32'(err_DM), 32'd0);
        check("rd8_vld", 32'(vld_DM), 32'd1);
        check("rd8_data", 32'(outDM), 32'h1111);
        drive(1'b1, 1'b0, 12'd31, 16'd0, 2'b11);
        step();
        check("rd31_err", 32'(err_DM), 32'd0);
        check("rd31_data", 32'(outDM), 32'd0);
        drive(1'b1, 1'b0, 12'd32, 16'd0, 2'b11);
        step();
        check("rd32_err", 32'(err_DM), 32'd1);
        check("rd32_vld", 32'(vld_DM), 32'd0);

        // Requests during CLEAR are ignored; reset mid-CLEAR restarts the sweep
        drive(1'b1, 1'b1, 12'd3, 16'h7777, 2'b11);
        step();
        rst = 1'b1;
        drive(1'b1, 1'b1, 12'd3, 16'hFFFF, 2'b11);
        step();
        rst = 1'b0;
        check("rst2_out", 32'(outDM), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("clear_rdy", 32'(rdy_DM), 32'd0);
            check("clear_err", 32'(err_DM), 32'd0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready("clear_len2", 32);
        drive(1'b1, 1'b0, 12'd3, 16'd0, 2'b11);
        step();
        check("rd3_vld", 32'(vld_DM), 32'd1);
        check("rd3_data", 32'(outDM), 32'd0);

        // Partial-word write
        drive(1'b1, 1'b1, 12'd1, 16'hAAAA, 2'b11);
        step();
        drive(1'b1, 1'b1, 12'd1, 16'h5555, 2'b01);
        step();
        drive(1'b1, 1'b0, 12'd1, 16'd0, 2'b11);
        step();
        check("rd1_vld", 32'(vld_DM), 32'd1);
`ifdef DATAMEM_BYTE_EN_EN
        check("rd1_be_data", 32'(outDM), 32'hAA55);
`else
        check("rd1_full_data", 32'(outDM), 32'h5555);
`endif
        drive(1'b0, 1'b0, 12'd0, 16'd0, 2'b11);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datamem_pipe.md
DATAMEM_PIPE -- requirements
Module: datamem_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 12, address port width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 32, number of implemented words, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port req_DM, input, 1, access request, qualified by rdy_DM.
REQ-007 The block SHALL have port we_DM, input, 1, where 1 selects a write and 0 selects a read; sampled with req_DM.
REQ-008 The block SHALL have port addDM, input, ADDR_W, word address.
REQ-009 The block SHALL have port dataDM, input, DATA_W, write data.
REQ-010 The block SHALL have port rdy_DM, output, 1, which is 1 when the block accepts a request this cycle.
REQ-011 The block SHALL have port outDM, output, DATA_W, registered read data.
REQ-012 The block SHALL have port vld_DM, output, 1, a one-cycle pulse marking valid outDM.
REQ-013 The block SHALL have port err_DM, output, 1, a one-cycle pulse when an accepted request has addDM >= DEPTH.

Function
REQ-014 The controller SHALL use two states: CLEAR and READY.
REQ-015 In CLEAR, the block SHALL write zero to word clr_ptr each cycle, increment clr_ptr, hold rdy_DM=0, and go to READY after word DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles.
REQ-016 In READY, rdy_DM SHALL be 1; a request is accepted on a cycle where req_DM=1 and rdy_DM=1.
REQ-017 A request presented while rdy_DM=0 SHALL be ignored, with no memory change and no vld_DM or err_DM pulse.
REQ-018 An accepted write with addDM < DEPTH SHALL update the memory at that rising edge, and vld_DM SHALL stay 0.
REQ-019 An accepted read with addDM < DEPTH SHALL drive outDM=mem[addDM] and vld_DM=1 in the next cycle, giving a read latency of 1.
REQ-020 outDM SHALL hold its last read value while vld_DM=0, and writes SHALL NOT alter outDM.
REQ-021 An accepted request with addDM >= DEPTH SHALL leave memory unchanged and pulse err_DM the next cycle; for a read, vld_DM stays 0 and outDM holds.
REQ-022 Back-to-back accepted requests, one per cycle, SHALL be supported; a read the cycle after a write to the same address SHALL return the new data.
REQ-023 Out-of-range detection SHALL compare the full ADDR_W address, with no wrap or aliasing into 0..DEPTH-1.

Reset
REQ-024 When rst=1, the block SHALL enter CLEAR with clr_ptr=0, rdy_DM=0, vld_DM=0, err_DM=0 and outDM=0.
REQ-025 A reset asserted mid-CLEAR or mid-READY SHALL restart CLEAR from address 0 and discard any in-flight read result.

Configuration
REQ-026 With DATAMEM_BYTE_EN_EN defined, the block SHALL add input be_DM of width DATA_W/8, and a write SHALL update only the bytes whose be_DM bit is 1; DATA_W must then be a multiple of 8.
REQ-027 Without DATAMEM_BYTE_EN_EN defined, the block SHALL have no be_DM port and every write SHALL update the full word.

Structure
REQ-028 Package datamem_pkg SHALL hold the state typedef (CLEAR, READY) and the default values of DATA_W, ADDR_W and DEPTH.
REQ-029 The storage array SHALL be a sub-module datamem_array, a single-port synchronous RAM with write enable, optional byte enable and registered read, and the controller SHALL multiplex clear writes and user accesses into it.

Verification
REQ-030 Reset test: drive rst for 1 cycle with defaults; rdy_DM SHALL be 0 for exactly 32 cycles and then 1; reading addresses 0..31 SHALL return 0x0000 each with vld_DM pulsing.
REQ-031 Write/read test: write 0xBEEF to address 5, then read address 5 on the next cycle; outDM SHALL be 0xBEEF with vld_DM=1 exactly one cycle after the read is accepted.
REQ-032 Out-of-range test: write 0x1234 to address 40, then read address 40; err_DM SHALL pulse after each request, vld_DM SHALL stay 0, and a read of address 8 (40 mod 32) SHALL return the value written there earlier.
REQ-033 Not-ready and mid-operation reset test: hold req_DM=1 with a write of 0xFFFF to address 3 during CLEAR, then assert rst at CLEAR cycle 10; the request SHALL be ignored, and after a full 32-cycle CLEAR, address 3 SHALL read 0x0000.
REQ-034 Byte-enable test, with DATAMEM_BYTE_EN_EN defined: write 0xAAAA to address 1, then write 0x5555 to address 1 with be_DM=2'b01; a read of address 1 SHALL return 0xAA55.
